// File: rtl/ntt_pkg.sv
// Shared constants, read-FSM state type and helpers for the NTT output reorder path.
package ntt_pkg;

  localparam int unsigned NTT_MODULUS = 7681;
  localparam int unsigned NTT_RADIX   = 16;
  localparam int unsigned NTT_W       = 32;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // Reverse the low nbits of value; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned nbits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < nbits) begin
        r[5'(nbits - 1 - i)] = value[5'(i)];
      end
    end
    return r;
  endfunction

  // Single conditional subtraction: maps [0, 2m) onto [0, m).
  function automatic logic [63:0] mod_reduce_once(input logic [63:0] x, input logic [63:0] m);
    return (x >= m) ? (x - m) : x;
  endfunction

endpackage

// File: rtl/ntt_pingpong_bank.sv
// Two-bank register file: one synchronous write port, one combinational read port.
module ntt_pingpong_bank #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data_c
);

  logic [W-1:0] mem_q [2][DEPTH];
  logic [W-1:0] mem_d [2][DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_bank][wr_addr] = wr_data;
    end
  end

  // Contents are data only; nothing downstream depends on their reset value.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_c = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// Reorders bit-reversed NTT frames into natural order through a ping-pong buffer,
// with an optional final conditional subtraction into [0, MODULUS).
module ntt_bitrev_reorder
  import ntt_pkg::*;
#(
  parameter int unsigned W       = NTT_W,
  parameter int unsigned MODULUS = NTT_MODULUS,
  parameter int unsigned RADIX   = NTT_RADIX,
  parameter int unsigned REDUCE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(RADIX)-1:0] out_index,
  output logic                     out_last
);

  localparam int unsigned AW = $clog2(RADIX);
  localparam logic [AW-1:0] CNT_MAX = AW'(RADIX - 1);
  localparam logic [W-1:0]  MOD_W   = W'(MODULUS);

  // Write side
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          fr_q, fr_d;
  logic          fr_bank_q, fr_bank_d;
  logic [AW-1:0] wr_addr_c;

  // Read side; pend_q holds a frame-ready that lands mid-drain
  rd_state_e     state_q, state_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic          pend_q, pend_d;
  logic          pend_bank_q, pend_bank_d;

  // Output register stage
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [AW-1:0] out_index_q, out_index_d;
  logic          out_last_q, out_last_d;

  logic [W-1:0]  rd_data_c;
  logic [W-1:0]  reduced_c;
  logic          start_c;
  logic          start_bank_c;

  assign wr_addr_c = AW'(bitrev(32'(wr_cnt_q), AW));

  ntt_pingpong_bank #(
    .W     (W),
    .DEPTH (RADIX),
    .AW    (AW)
  ) u_bank (
    .clk       (clk),
    .we        (in_valid),
    .wr_bank   (wr_bank_q),
    .wr_addr   (wr_addr_c),
    .wr_data   (in_data),
    .rd_bank   (rd_bank_q),
    .rd_addr   (rd_cnt_q),
    .rd_data_c (rd_data_c)
  );

  assign reduced_c = (REDUCE != 0) ? W'(mod_reduce_once(64'(rd_data_c), 64'(MOD_W))) : rd_data_c;

  assign start_c      = fr_q | pend_q;
  assign start_bank_c = fr_q ? fr_bank_q : pend_bank_q;

  // Write counter, bank toggle and frame-ready pulse
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    fr_d      = 1'b0;
    fr_bank_d = fr_bank_q;
    if (in_valid) begin
      if (wr_cnt_q == CNT_MAX) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
        fr_d      = 1'b1;
        fr_bank_d = wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end
  end

  // Drain FSM and output stage
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_index_d = '0;
    out_last_d  = 1'b0;

    unique case (state_q)
      RD_IDLE: begin
        if (start_c) begin
          state_d   = RD_DRAIN;
          rd_cnt_d  = '0;
          rd_bank_d = start_bank_c;
          pend_d    = 1'b0;
        end
      end
      RD_DRAIN: begin
        out_valid_d = 1'b1;
        out_data_d  = reduced_c;
        out_index_d = rd_cnt_q;
        out_last_d  = (rd_cnt_q == CNT_MAX);
        if (rd_cnt_q == CNT_MAX) begin
          // Chain straight into the next frame when one is already waiting
          if (start_c) begin
            rd_cnt_d  = '0;
            rd_bank_d = start_bank_c;
            pend_d    = 1'b0;
          end else begin
            state_d = RD_IDLE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + AW'(1);
          if (fr_q) begin
            pend_d      = 1'b1;
            pend_bank_d = fr_bank_q;
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      fr_q        <= 1'b0;
      fr_bank_q   <= 1'b0;
      state_q     <= RD_IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      fr_q        <= fr_d;
      fr_bank_q   <= fr_bank_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Scoreboard bench for ntt_bitrev_reorder: one reducing and one pass-through instance fed the same stream.
module tb_ntt_bitrev_reorder;

  localparam int unsigned W     = 32;
  localparam int unsigned RADIX = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned MODV  = 7681;

  typedef logic [W-1:0] frame_t [RADIX];

  typedef struct {
    logic [W-1:0]  red;
    logic [W-1:0]  raw;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp_out;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          r_valid, p_valid;
  logic [W-1:0]  r_data, p_data;
  logic [AW-1:0] r_index, p_index;
  logic          r_last, p_last;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   run_cur = 0;
  int   last_run = 0;
  bit   prev_valid = 1'b0;
  bit   lat_armed = 1'b0;
  int   lat_exp = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ntt_bitrev_reorder #(.W(W), .MODULUS(MODV), .RADIX(RADIX), .REDUCE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(r_valid), .out_data(r_data), .out_index(r_index), .out_last(r_last)
  );

  ntt_bitrev_reorder #(.W(W), .MODULUS(MODV), .RADIX(RADIX), .REDUCE(0)) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(p_valid), .out_data(p_data), .out_index(p_index), .out_last(p_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [AW-1:0] tb_bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < int'(AW); i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  task automatic model(input frame_t arr, output frame_t red, output frame_t raw);
    for (int j = 0; j < int'(RADIX); j++) begin
      raw[j] = arr[tb_bitrev(AW'(j))];
      red[j] = (raw[j] >= MODV) ? raw[j] - MODV : raw[j];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_frame(input frame_t arr, input frame_t red, input frame_t raw,
                             input bit gaps, input bit check_lat);
    for (int i = 0; i < int'(RADIX); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = arr[i];
      if (i == int'(RADIX) - 1) begin
        for (int j = 0; j < int'(RADIX); j++)
          sb.push_back('{red[j], raw[j], AW'(j), j == int'(RADIX) - 1});
        if (check_lat) begin
          lat_exp   = cyc + 3;
          lat_armed = 1'b1;
        end
      end else if (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
  endtask

  // Output monitor: pops the scoreboard on every valid beat
  always @(negedge clk) begin
    if (rst) begin
      chk("valid_pair", 32'(p_valid), 32'(r_valid));
      if (r_valid) begin
        if (!prev_valid && lat_armed) begin
          chk("first_valid_edge", 32'(cyc), 32'(lat_exp));
          lat_armed = 1'b0;
        end
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data_reduced", r_data, e.red);
          chk("out_data_raw", p_data, e.raw);
          chk("out_index", 32'(r_index), 32'(e.idx));
          chk("out_last", 32'(r_last), 32'(e.last));
        end
        run_cur++;
      end else if (run_cur > 0) begin
        last_run = run_cur;
        run_cur  = 0;
      end
      prev_valid = r_valid;
    end else begin
      prev_valid = 1'b0;
      run_cur    = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   s1_tab [RADIX];
    vec_t   red_tab [4];
    frame_t arr, red, raw;
    bit     found;
    int     exp_seq [RADIX] = '{100, 108, 104, 112, 102, 110, 106, 114,
                                101, 109, 105, 113, 103, 111, 107, 115};

    for (int i = 0; i < int'(RADIX); i++) s1_tab[i] = '{W'(100 + i), W'(exp_seq[i])};
    red_tab[0] = '{32'd7680,  32'd7680};
    red_tab[1] = '{32'd7681,  32'd0};
    red_tab[2] = '{32'd7690,  32'd9};
    red_tab[3] = '{32'd15361, 32'd7680};

    // Reset state
    #12;
    chk("rst_out_valid", 32'(r_valid), 32'd0);
    chk("rst_out_data", r_data, 32'd0);
    chk("rst_out_index", 32'(r_index), 32'd0);
    chk("rst_out_last", 32'(r_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Single frame, expected order straight from the table
    for (int i = 0; i < int'(RADIX); i++) begin
      arr[i] = s1_tab[i].din;
      red[i] = s1_tab[i].exp_out;
      raw[i] = s1_tab[i].exp_out;
    end
    drive_frame(arr, red, raw, 1'b0, 1'b1);
    idle(24);
    chk("s1_run_len", 32'(last_run), 32'd16);

    // Three back-to-back frames
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < int'(RADIX); i++) arr[i] = W'(f * 16 + i);
      model(arr, red, raw);
      drive_frame(arr, red, raw, 1'b0, f == 0);
    end
    idle(24);
    chk("b2b_run_len", 32'(last_run), 32'd48);

    // Gapped input, same values as the single frame
    for (int i = 0; i < int'(RADIX); i++) begin
      arr[i] = s1_tab[i].din;
      red[i] = s1_tab[i].exp_out;
      raw[i] = s1_tab[i].exp_out;
    end
    drive_frame(arr, red, raw, 1'b1, 1'b1);
    idle(24);
    chk("gap_run_len", 32'(last_run), 32'd16);

    // Reduction: natural indices 0..3 carry the table inputs
    for (int j = 0; j < int'(RADIX); j++) begin
      red[j] = '0;
      raw[j] = '0;
      arr[j] = '0;
    end
    for (int j = 0; j < 4; j++) begin
      arr[tb_bitrev(AW'(j))] = red_tab[j].din;
      red[j] = red_tab[j].exp_out;
      raw[j] = red_tab[j].din;
    end
    drive_frame(arr, red, raw, 1'b0, 1'b1);
    idle(24);

    // Gapped frame followed immediately by a continuous one: drains must abut
    for (int i = 0; i < int'(RADIX); i++) arr[i] = W'(300 + i);
    model(arr, red, raw);
    drive_frame(arr, red, raw, 1'b1, 1'b0);
    for (int i = 0; i < int'(RADIX); i++) arr[i] = W'(400 + 7 * i);
    model(arr, red, raw);
    drive_frame(arr, red, raw, 1'b0, 1'b0);
    idle(24);
    chk("abut_run_len", 32'(last_run), 32'd32);

    // Reset mid-drain, with a partial next frame already in flight
    for (int i = 0; i < int'(RADIX); i++) arr[i] = W'(500 + i);
    model(arr, red, raw);
    drive_frame(arr, red, raw, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = W'(900 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(posedge clk);
      #1;
      if (r_valid && r_index == AW'(5)) found = 1'b1;
    end
    chk("reach_index5", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(r_valid), 32'd0);
    chk("mid_rst_data", r_data, 32'd0);
    chk("mid_rst_index", 32'(r_index), 32'd0);
    chk("mid_rst_last", 32'(r_last), 32'd0);
    chk("mid_rst_valid_nr", 32'(p_valid), 32'd0);
    sb.delete();
    lat_armed = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    for (int i = 0; i < int'(RADIX); i++) begin
      arr[i] = s1_tab[i].din;
      red[i] = s1_tab[i].exp_out;
      raw[i] = s1_tab[i].exp_out;
    end
    drive_frame(arr, red, raw, 1'b0, 1'b1);
    idle(24);
    chk("post_rst_run_len", 32'(last_run), 32'd16);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ntt_bitrev_reorder.md
Name: ntt_bitrev_reorder

Overview:
- Output-side reader for the streaming forward-NTT pipeline.
- Consumes the serial, bit-reversed-order coefficient stream of each RADIX-point frame and emits it in natural order, one coefficient per clock.
- Ping-pong buffering sustains back-to-back frames without stalls.
- An optional final conditional subtraction leaves each output fully reduced into [0, MODULUS).

Parameters:
- W, 32, data width.
- MODULUS, 7681, NTT prime; used by the final reduction.
- RADIX, 16, points per frame; power of two, minimum 4.
- REDUCE, 1, 1 = apply out = (x >= MODULUS) ? x - MODULUS : x; 0 = pass through.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data carries a coefficient this cycle.
- in_data  input  W  coefficient, arriving in bit-reversed order; value range [0, 2*MODULUS).
- out_valid  output  1  out_data valid this cycle.
- out_data  output  W  coefficient, natural order.
- out_index  output  log2(RADIX)  natural index of out_data.
- out_last  output  1  high with index RADIX-1.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - wr_cnt, wr_bank, rd_cnt, rd_busy, rd_bank.
  - out_valid=0, out_data=0, out_index=0, out_last=0.
  - Buffer contents need no reset.
- Storage: two banks of RADIX x W registers.
- Write side:
  - On each edge with in_valid=1, in_data is written to bank[wr_bank] at address bitrev(wr_cnt) over log2(RADIX) bits, and wr_cnt increments.
  - When wr_cnt=RADIX-1 is written, wr_cnt wraps to 0, wr_bank toggles, and a "frame ready" pulse is raised for the filled bank.
  - in_valid may drop at any time; wr_cnt holds and the partial frame resumes when in_valid returns.
- Read side (states IDLE, DRAIN):
  - IDLE -> DRAIN on the cycle after frame-ready; rd_bank = filled bank, rd_cnt=0.
  - DRAIN: each cycle reads bank[rd_bank][rd_cnt] combinationally into the output register stage (with optional reduction) and increments rd_cnt.
  - DRAIN ends after rd_cnt=RADIX-1. Go to IDLE, or restart DRAIN immediately if another frame-ready occurred.
  - The drain never stalls: no backpressure.
- Latency: if the last sample of a frame is sampled at edge k, out_valid is high for the cycles following edges k+2 .. k+RADIX+1.
  - Index 0 appears after edge k+2.
  - out_last is coincident with index RADIX-1.
- Throughput: a frame occupies the write bank for at least RADIX cycles, and a drain reads for exactly RADIX cycles.
  - Consequently a bank is never written while it is being read, and overflow cannot occur.
  - Back-to-back frames therefore produce contiguous out_valid with no bubble.
- Simultaneous events:
  - A frame-ready in the same cycle as the last drain read starts the next drain on the following cycle with no gap.
  - Writing and reading proceed concurrently on opposite banks.
- Reduction: compare against MODULUS is unsigned at width W.
  - Inputs >= 2*MODULUS are outside contract; output is unspecified but out_valid timing is unaffected.
- Reset mid-operation aborts any partial frame and any drain. The first frame after reset starts at wr_cnt=0.

Decomposition:
- ntt_pkg holds:
  - Constants: NTT_MODULUS=7681, NTT_RADIX=16, NTT_W=32.
  - Function bitrev(value, nbits).
  - Function mod_reduce_once(x, m).
- One sub-module, ntt_pingpong_bank: 2 x RADIX x W register file with one write port (bank, addr, data, we) and one combinational read port (bank, addr).
- FSM and counters stay in the top block.

Test Plan:
- Single frame, RADIX=16, in_data at arrival i = 100+i, in_valid continuous.
  - Required out_data sequence: 100,108,104,112,102,110,106,114,101,109,105,113,103,111,107,115.
  - out_index runs 0..15; out_last only on 115.
  - First out_valid exactly 2 edges after the 16th input edge.
- Three back-to-back frames, values 0..47 in arrival order.
  - out_valid stays high for 48 consecutive cycles.
  - Each frame is reordered as above with offsets 0, 16, 32.
- Input with gaps: in_valid toggles 1,0,1,0 across one frame.
  - Output is identical to scenario 1 values.
  - The drain is contiguous over 16 cycles.
- Reduction, REDUCE=1, with inputs 7680, 7681, 7690, 15361 at indices 0..3 (remaining indices 0).
  - Outputs at their natural positions: 7680, 0, 9, 7680.
  - With REDUCE=0 the inputs pass unchanged.
- Reset mid-drain: assert rst at output index 5.
  - out_valid drops immediately (asynchronous); outputs return to 0.
  - A fresh frame after release reorders correctly with no stale data.
- Frame completes on the same cycle as the previous drain's out_last region.
  - The new drain starts with no idle cycle.
  - No corruption of either frame.
